// File: rtl/sim_top_pkg.sv
// sim_top_pkg: frame geometry and FSM encoding shared by the C2H frame sender.
package sim_top_pkg;
  localparam int FRAME_W = 16000;
  localparam int BEAT_W = 512;
  localparam int BEATS = (FRAME_W + BEAT_W - 1) / BEAT_W;
  localparam int BEAT_IW = $clog2(BEATS);
  localparam int PAD_W = BEATS * BEAT_W;
  typedef enum logic [1:0] {REQ, WAIT, SEND} state_e;
endpackage

// File: rtl/sim_top_frame_beat_mux.sv
// frame_beat_mux: selects one zero-padded BEAT_W slice of a frame by beat index.
module frame_beat_mux
  import sim_top_pkg::*;
(
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [BEAT_IW-1:0] beat_i,
  output logic [BEAT_W-1:0]  beat_o
);
  logic [PAD_W-1:0] padded;
  assign padded = {{(PAD_W - FRAME_W){1'b0}}, frame_i};
  assign beat_o = padded[beat_i * BEAT_W +: BEAT_W];
endmodule

// File: rtl/sim_top.sv
// sim_top: requests a frame, captures it, and streams it as AXI-Stream beats
// with TLAST on the final beat; core_clk strobes once per captured frame.
module sim_top
  import sim_top_pkg::*;
(
  input  logic                m_axis_c2h_aclk,
  input  logic                rst_en,
  input  logic                io_enable,
  input  logic [FRAME_W-1:0]  io_data,
  output logic                data_next,
  output logic                core_clk,
  output logic [BEAT_W-1:0]   m_axis_c2h_tdata,
  output logic [BEAT_W/8-1:0] m_axis_c2h_tkeep,
  output logic                m_axis_c2h_tvalid,
  output logic                m_axis_c2h_tlast,
  input  logic                m_axis_c2h_tready
);
  state_e state_q, state_d;
  logic [BEAT_IW-1:0] beat_q, beat_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BEAT_W-1:0] tdata_q, beat_data;
  logic data_next_q, data_next_d, core_clk_q, core_clk_d;
  logic tvalid_q, tlast_q, hs, last;
  assign hs = tvalid_q && m_axis_c2h_tready;
  assign last = beat_q == BEAT_IW'(BEATS - 1);
  // REQ spends a cycle raising data_next before it is visible, unless entered
  // from SEND where the pulse is already registered on the final handshake.
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    frame_d = frame_q;
    data_next_d = 1'b0;
    core_clk_d = 1'b0;
    case (state_q)
      REQ: begin
        data_next_d = !data_next_q;
        state_d = data_next_q ? WAIT : REQ;
      end
      WAIT: if (io_enable) begin
        frame_d = io_data;
        beat_d = '0;
        state_d = SEND;
        core_clk_d = 1'b1;
      end
      SEND: if (hs) begin
        beat_d = last ? beat_q : beat_q + 1'b1;
        state_d = last ? REQ : SEND;
        data_next_d = last;
      end
      default: state_d = REQ;
    endcase
  end
  frame_beat_mux u_mux (
    .frame_i(frame_d),
    .beat_i (beat_d),
    .beat_o (beat_data)
  );
  // Stream outputs are computed from next-state so they are registered yet
  // already valid on the first SEND cycle, and hold naturally under stall.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (rst_en) begin
      state_q <= REQ;
      beat_q <= '0;
      frame_q <= '0;
      data_next_q <= 1'b0;
      core_clk_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      frame_q <= frame_d;
      data_next_q <= data_next_d;
      core_clk_q <= core_clk_d;
      tvalid_q <= state_d == SEND;
      tlast_q <= state_d == SEND && beat_d == BEAT_IW'(BEATS - 1);
      tdata_q <= state_d == SEND ? beat_data : '0;
    end
  end
  assign data_next = data_next_q;
  assign core_clk = core_clk_q;
  assign m_axis_c2h_tdata = tdata_q;
  assign m_axis_c2h_tkeep = '1;
  assign m_axis_c2h_tvalid = tvalid_q;
  assign m_axis_c2h_tlast = tlast_q;
endmodule

// File: tb/tb_sim_top.sv
// tb_sim_top: directed self-checking bench for the C2H frame sender.
module tb_sim_top;
  logic clk = 1'b0;
  logic rst_en = 1'b1;
  logic io_enable = 1'b0;
  logic [15999:0] io_data = '0;
  logic data_next, core_clk, tvalid, tlast, tready = 1'b1;
  logic [511:0] tdata;
  logic [63:0] tkeep;
  logic [16383:0] exp_frame;
  int n_cmp = 0;
  int n_err = 0;
  sim_top dut (
    .m_axis_c2h_aclk  (clk),
    .rst_en           (rst_en),
    .io_enable        (io_enable),
    .io_data          (io_data),
    .data_next        (data_next),
    .core_clk         (core_clk),
    .m_axis_c2h_tdata (tdata),
    .m_axis_c2h_tkeep (tkeep),
    .m_axis_c2h_tvalid(tvalid),
    .m_axis_c2h_tlast (tlast),
    .m_axis_c2h_tready(tready)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_frame(input logic [15999:0] d);
    io_data = d;
    exp_frame = '0;
    exp_frame[15999:0] = d;
  endtask
  // Entered at the negedge where beat 0 is visible; leaves in the REQ cycle.
  task automatic run_frame(input int bp_beat);
    logic [511:0] held;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("tvalid_b%0d", k), 512'(tvalid), 512'(1));
      chk($sformatf("tdata_b%0d", k), tdata, exp_frame[k*512 +: 512]);
      chk($sformatf("tlast_b%0d", k), 512'(tlast), 512'(k == 31));
      chk($sformatf("tkeep_b%0d", k), 512'(tkeep), {448'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      if (k == 1) chk("core_clk_one_cycle", 512'(core_clk), 512'(0));
      if (k == bp_beat) begin
        held = tdata;
        tready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          step();
          chk("bp_tvalid_hold", 512'(tvalid), 512'(1));
          chk("bp_tdata_hold", tdata, held);
          chk("bp_tlast_hold", 512'(tlast), 512'(0));
        end
        tready = 1'b1;
      end
      step();
    end
    chk("end_tvalid_drop", 512'(tvalid), 512'(0));
    chk("end_data_next", 512'(data_next), 512'(1));
  endtask
  initial begin
    int pulses;
    logic [15999:0] pat;
    tready = 1'b1;
    set_frame('0);
    repeat (10) step();
    chk("rst_data_next", 512'(data_next), 512'(0));
    chk("rst_tvalid", 512'(tvalid), 512'(0));
    chk("rst_tlast", 512'(tlast), 512'(0));
    chk("rst_core_clk", 512'(core_clk), 512'(0));
    chk("rst_tdata", tdata, 512'(0));
    rst_en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) chk("rel_first_pulse", 512'(data_next), 512'(1));
      pulses += int'(data_next);
      chk("rel_tvalid", 512'(tvalid), 512'(0));
      chk("rel_core_clk", 512'(core_clk), 512'(0));
    end
    chk("rel_pulse_count", 512'(pulses), 512'(1));
    set_frame(16000'(1));
    io_enable = 1'b1;
    step();
    chk("f1_core_clk", 512'(core_clk), 512'(1));
    run_frame(-1);
    step();
    chk("stale_no_capture_tvalid", 512'(tvalid), 512'(0));
    chk("stale_no_capture_core", 512'(core_clk), 512'(0));
    chk("stale_pulse_single", 512'(data_next), 512'(0));
    set_frame(16000'(2));
    step();
    chk("f2_core_clk", 512'(core_clk), 512'(1));
    chk("f2_first_beat", tdata, 512'(2));
    run_frame(-1);
    pat = '0;
    for (int k = 0; k < 32; k++) pat[k*512 +: 32] = 32'(k + 1);
    set_frame(pat);
    step();
    step();
    chk("f3_beat5_tag", tdata, 512'(1));
    run_frame(5);
    set_frame('1);
    step();
    step();
    run_frame(-1);
    chk("pad_beat31_hand", exp_frame[31*512 +: 512], {384'd0, {128{1'b1}}});
    set_frame(pat);
    step();
    step();
    repeat (10) step();
    chk("mid_beat10", tdata, 512'(11));
    rst_en = 1'b1;
    io_enable = 1'b0;
    step();
    chk("mid_rst_tvalid", 512'(tvalid), 512'(0));
    chk("mid_rst_tdata", tdata, 512'(0));
    chk("mid_rst_tlast", 512'(tlast), 512'(0));
    rst_en = 1'b0;
    step();
    chk("mid_rel_pulse", 512'(data_next), 512'(1));
    step();
    chk("mid_rel_pulse_end", 512'(data_next), 512'(0));
    set_frame(16000'(3));
    io_enable = 1'b1;
    step();
    chk("mid_fresh_core", 512'(core_clk), 512'(1));
    chk("mid_fresh_beat0", tdata, 512'(3));
    run_frame(-1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
